// File: rtl/jump_pkg.sv
// Shared definitions for the jump datapath: top-level state codes, the
// release-block FSM encoding and default trajectory/tick constants.
package jump_pkg;

  // Top-level game state codes, shared with the squeeze counter and top FSM.
  typedef enum logic [2:0] {
    TOP_IDLE = 3'd0,
    TOP_ACCU = 3'd1,
    TOP_JUMP = 3'd2,
    TOP_LAND = 3'd3,
    TOP_OVER = 3'd4
  } top_state_e;

  // Local FSM of the jump-release block. MJ_RECOIL is only reachable when
  // the landing recoil feature is compiled in.
  typedef enum logic [1:0] {
    MJ_IDLE   = 2'd0,
    MJ_FLIGHT = 2'd1,
    MJ_RECOIL = 2'd2
  } mj_state_e;

  localparam int unsigned V0_DEFAULT     = 8;
  localparam int unsigned TICK_W_DEFAULT = 20;

  // Number of frames a jump lasts: vy runs V0 .. -V0 inclusive.
  function automatic int unsigned flight_frames(input int unsigned v0);
    return 2 * v0 + 1;
  endfunction

  // Signed vy register width: must hold +V0 and -(V0+1) after the last step.
  function automatic int unsigned vy_width(input int unsigned v0);
    return $clog2(v0) + 2;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame-tick divider: one single-cycle tick every 2^TICK_W
// clocks, asserted while the counter is all-ones.
module frame_tick_gen
  import jump_pkg::*;
#(
  parameter int unsigned TICK_W = TICK_W_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [TICK_W-1:0] cnt_q;

  // Wrap-around counter; the all-ones value marks the frame boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TICK_W'(1);
    end
  end

  assign tick_o = &cnt_q;

endmodule

// File: rtl/man_jump_release.sv
// Jump release: latches the squeeze level on the ACCU->JUMP transition and
// plays out a frame-stepped ballistic trajectory (o_dx, o_dy), reporting
// touchdown with a one-cycle o_land pulse.
// Optional landing recoil is enabled by defining MAN_JUMP_RECOIL_EN.
module man_jump_release
  import jump_pkg::*;
#(
  parameter int unsigned TICK_W = TICK_W_DEFAULT,
  parameter int unsigned V0     = V0_DEFAULT,
  parameter int unsigned DX_W   = 10,
  parameter int unsigned DY_W   = 8
) (
  input  logic            clk_machine,
  input  logic            rst_machine,
  input  logic [2:0]      state,
  input  logic [2:0]      squeeze_lvl,
  output logic [DX_W-1:0] o_dx,
  output logic [DY_W-1:0] o_dy,
  output logic            o_jumping,
  output logic            o_land,
  output logic [2:0]      o_squeeze_man
);

  localparam int unsigned FRAMES = flight_frames(V0);
  localparam int unsigned VY_W   = vy_width(V0);
  localparam int unsigned FR_W   = $clog2(FRAMES + 1);

  logic tick;

  mj_state_e               fsm_q, fsm_d;
  logic [2:0]              prev_state_q;
  logic [2:0]              charge_q, charge_d;
  logic signed [VY_W-1:0]  vy_q, vy_d;
  logic [FR_W-1:0]         frame_q, frame_d;
  logic [DX_W-1:0]         dx_q, dx_d;
  logic [DY_W-1:0]         dy_q, dy_d;
  logic                    jumping_q, jumping_d;
  logic                    land_q, land_d;
  logic                    take_off;

`ifdef MAN_JUMP_RECOIL_EN
  localparam logic [2:0] RECOIL_LVL = 3'd3;
  logic [2:0]            sqz_q, sqz_d;
`endif

  frame_tick_gen #(
    .TICK_W (TICK_W)
  ) u_frame_tick (
    .clk_i  (clk_machine),
    .rst_ni (rst_machine),
    .tick_o (tick)
  );

  // Take-off is the ACCU->JUMP edge of the top FSM, seen on the edge it happens.
  assign take_off = (prev_state_q == TOP_ACCU) && (state == TOP_JUMP);

  // Next-state and datapath update; every register holds unless told otherwise.
  always_comb begin
    fsm_d     = fsm_q;
    charge_d  = charge_q;
    vy_d      = vy_q;
    frame_d   = frame_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    jumping_d = jumping_q;
    land_d    = 1'b0;
`ifdef MAN_JUMP_RECOIL_EN
    sqz_d     = sqz_q;
`endif

    case (fsm_q)
      MJ_IDLE: begin
        // A tick on the take-off edge is deliberately not applied.
        if (take_off) begin
          fsm_d     = MJ_FLIGHT;
          charge_d  = squeeze_lvl;
          vy_d      = VY_W'(V0);
          frame_d   = '0;
          dx_d      = '0;
          dy_d      = '0;
          jumping_d = 1'b1;
        end
      end

      MJ_FLIGHT: begin
        if (state != TOP_JUMP) begin
          // Aborted jump: drop to the ground line, keep horizontal progress.
          fsm_d     = MJ_IDLE;
          dy_d      = '0;
          jumping_d = 1'b0;
        end else if (tick) begin
          dx_d    = dx_q + DX_W'(charge_q) + DX_W'(1);
          // Sign-extended vy added modulo 2^DY_W; the true result is never negative.
          dy_d    = dy_q + DY_W'(vy_q);
          vy_d    = vy_q - VY_W'(1);
          frame_d = frame_q + FR_W'(1);
          if (frame_q == FR_W'(FRAMES - 1)) begin
            land_d    = 1'b1;
            jumping_d = 1'b0;
`ifdef MAN_JUMP_RECOIL_EN
            fsm_d     = MJ_RECOIL;
            sqz_d     = RECOIL_LVL;
`else
            fsm_d     = MJ_IDLE;
`endif
          end
        end
      end

`ifdef MAN_JUMP_RECOIL_EN
      MJ_RECOIL: begin
        // Recoil runs to completion; aborts and new take-offs are ignored.
        if (tick) begin
          sqz_d = sqz_q - 3'd1;
          if (sqz_q == 3'd1) begin
            fsm_d = MJ_IDLE;
          end
        end
      end
`endif

      default: begin
        fsm_d = MJ_IDLE;
      end
    endcase
  end

  // State register plus registered outputs, cleared asynchronously.
  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      fsm_q        <= MJ_IDLE;
      prev_state_q <= TOP_IDLE;
      charge_q     <= '0;
      vy_q         <= '0;
      frame_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      jumping_q    <= 1'b0;
      land_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= state;
      charge_q     <= charge_d;
      vy_q         <= vy_d;
      frame_q      <= frame_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      jumping_q    <= jumping_d;
      land_q       <= land_d;
    end
  end

`ifdef MAN_JUMP_RECOIL_EN
  // Recoil level register, only present with the recoil feature.
  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      sqz_q <= '0;
    end else begin
      sqz_q <= sqz_d;
    end
  end

  assign o_squeeze_man = sqz_q;
`else
  assign o_squeeze_man = 3'd0;
`endif

  assign o_dx      = dx_q;
  assign o_dy      = dy_q;
  assign o_jumping = jumping_q;
  assign o_land    = land_q;

endmodule

// File: tb/tb_man_jump_release.sv
// Scoreboard bench for man_jump_release (TICK_W=4, V0=8). Expected trajectory
// points are pushed at take-off from the closed-form ballistic formula and
// popped whenever o_dx steps.
module tb_man_jump_release;
  import jump_pkg::*;

  localparam int TICK_W   = 4;
  localparam int V0       = 8;
  localparam int DX_W     = 10;
  localparam int DY_W     = 8;
  localparam int STEP_CYC = 1 << TICK_W;
  localparam int FRAMES   = 2 * V0 + 1;

  typedef struct {
    int k;
    int dx;
    int dy;
    bit land;
  } step_t;

  logic            clk_machine = 1'b0;
  logic            rst_machine = 1'b0;
  logic [2:0]      state       = 3'd0;
  logic [2:0]      squeeze_lvl = 3'd0;
  logic [DX_W-1:0] o_dx;
  logic [DY_W-1:0] o_dy;
  logic            o_jumping;
  logic            o_land;
  logic [2:0]      o_squeeze_man;

  step_t sb_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    land_seen    = 0;
  int    last_dx      = 0;

  man_jump_release #(
    .TICK_W (TICK_W),
    .V0     (V0),
    .DX_W   (DX_W),
    .DY_W   (DY_W)
  ) dut (
    .clk_machine   (clk_machine),
    .rst_machine   (rst_machine),
    .state         (state),
    .squeeze_lvl   (squeeze_lvl),
    .o_dx          (o_dx),
    .o_dy          (o_dy),
    .o_jumping     (o_jumping),
    .o_land        (o_land),
    .o_squeeze_man (o_squeeze_man)
  );

  always #5 clk_machine = ~clk_machine;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, exp);
    end
  endtask

  // Expected trajectory: after k ticks dx = k*(c+1), dy = k*V0 - k(k-1)/2.
  task automatic push_flight(input int lvl, input int n);
    for (int k = 1; k <= n; k++) begin
      step_t e;
      e.k    = k;
      e.dx   = k * (lvl + 1);
      e.dy   = k * V0 - (k * (k - 1)) / 2;
      e.land = (k == FRAMES);
      sb_q.push_back(e);
    end
  endtask

  // Caller sits on a negedge; drives ACCU then JUMP and checks the take-off.
  task automatic take_off(input int lvl);
    state       = TOP_ACCU;
    squeeze_lvl = 3'(lvl);
    @(negedge clk_machine);
    state = TOP_JUMP;
    @(negedge clk_machine);
    last_dx = 0;
    check_eq("takeoff_jumping", o_jumping, 1);
    check_eq("takeoff_dx", o_dx, 0);
    check_eq("takeoff_dy", o_dy, 0);
  endtask

  // Waits (bounded) for o_dx to step, then pops and compares one scoreboard entry.
  task automatic wait_step(input bit chk_gap);
    int    n;
    step_t e;
    n = 0;
    do begin
      @(negedge clk_machine);
      n++;
      if (o_land) land_seen++;
    end while (int'(o_dx) == last_dx && n < 4 * STEP_CYC);
    check_eq("step_seen", int'(o_dx) != last_dx, 1);
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_eq($sformatf("dx[%0d]", e.k), o_dx, e.dx);
      check_eq($sformatf("dy[%0d]", e.k), o_dy, e.dy);
      check_eq($sformatf("land[%0d]", e.k), o_land, int'(e.land));
      check_eq($sformatf("jumping[%0d]", e.k), o_jumping, int'(!e.land));
      if (chk_gap) check_eq($sformatf("gap[%0d]", e.k), n, STEP_CYC);
    end
    last_dx = int'(o_dx);
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_machine);
      if (o_land) land_seen++;
    end
  endtask

  task automatic run_flight(input int lvl, input int n);
    push_flight(lvl, n);
    take_off(lvl);
    for (int i = 0; i < n; i++) wait_step(i != 0);
  endtask

`ifdef MAN_JUMP_RECOIL_EN
  // Landing cycle: recoil starts at 3 and counts down once per tick, while an
  // ACCU->JUMP edge and an abort are driven and must be ignored.
  task automatic recoil_check();
    check_eq("recoil_start", o_squeeze_man, 3);
    state = TOP_ACCU;
    for (int v = 2; v >= 0; v--) begin
      int         n;
      logic [2:0] prev_sq;
      n       = 0;
      prev_sq = o_squeeze_man;
      do begin
        @(negedge clk_machine);
        n++;
        if (v == 2 && n == 1) state = TOP_JUMP;
        if (v == 2 && n == 2) state = TOP_IDLE;
        if (o_land) land_seen++;
      end while (o_squeeze_man == prev_sq && n < 4 * STEP_CYC);
      check_eq($sformatf("recoil_lvl[%0d]", v), o_squeeze_man, v);
      check_eq($sformatf("recoil_gap[%0d]", v), n, STEP_CYC);
      check_eq($sformatf("recoil_no_jump[%0d]", v), o_jumping, 0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    state       = TOP_IDLE;
    squeeze_lvl = 3'd0;
    idle_wait(3);
    check_eq("rst_dx", o_dx, 0);
    check_eq("rst_dy", o_dy, 0);
    check_eq("rst_jumping", o_jumping, 0);
    check_eq("rst_land", o_land, 0);
    check_eq("rst_sqz_man", o_squeeze_man, 0);
    rst_machine = 1'b1;
    idle_wait(5);

    // Full jump at maximum charge
    land_seen = 0;
    run_flight(7, FRAMES);
    check_eq("max_land_count", land_seen, 1);
    check_eq("max_final_dx", o_dx, 136);

    // Recoil (or none), then immediate re-take-off and abort
`ifdef MAN_JUMP_RECOIL_EN
    recoil_check();
`else
    check_eq("sqz_man_off", o_squeeze_man, 0);
`endif
    take_off(2);
    state = TOP_IDLE;
    @(negedge clk_machine);
    check_eq("retake_abort_jumping", o_jumping, 0);
    check_eq("retake_abort_dy", o_dy, 0);
    idle_wait(2);

    // Minimum charge; squeeze_lvl changes after take-off are ignored
    land_seen = 0;
    push_flight(0, FRAMES);
    take_off(0);
    squeeze_lvl = 3'd5;
    for (int i = 0; i < FRAMES; i++) wait_step(i != 0);
    check_eq("min_final_dx", o_dx, 17);
    idle_wait(4 * STEP_CYC);
    check_eq("min_dx_hold", o_dx, 17);
    check_eq("min_land_count", land_seen, 1);

    // Abort after five ticks
    land_seen = 0;
    run_flight(3, 5);
    state = TOP_IDLE;
    @(negedge clk_machine);
    check_eq("abort_dy", o_dy, 0);
    check_eq("abort_jumping", o_jumping, 0);
    check_eq("abort_dx", o_dx, 20);
    idle_wait(40);
    check_eq("abort_dx_hold", o_dx, 20);
    check_eq("abort_no_land", land_seen, 0);

    // JUMP without a preceding ACCU
    state = TOP_JUMP;
    idle_wait(40);
    check_eq("noaccu_jumping", o_jumping, 0);
    check_eq("noaccu_dx", o_dx, 20);
    check_eq("noaccu_dy", o_dy, 0);

    // Reset mid-flight
    land_seen = 0;
    run_flight(4, 3);
    #3 rst_machine = 1'b0;
    #1;
    check_eq("midrst_dx", o_dx, 0);
    check_eq("midrst_dy", o_dy, 0);
    check_eq("midrst_jumping", o_jumping, 0);
    check_eq("midrst_land", o_land, 0);
    check_eq("midrst_sqz_man", o_squeeze_man, 0);
    idle_wait(2);
    rst_machine = 1'b1;
    idle_wait(40);
    check_eq("postrst_jumping", o_jumping, 0);
    check_eq("postrst_dx", o_dx, 0);
    check_eq("postrst_no_land", land_seen, 0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/man_jump_release.md
Name: man_jump_release

Overview:
- Receiving end of the charge interface. Charge (squeeze) is accumulated while the top-level FSM is in ACCU.
- This block consumes the squeeze level when the top-level FSM leaves ACCU for JUMP, and converts it into a frame-stepped jump trajectory (horizontal and vertical offsets).
- It reports landing to the top-level FSM and drives the renderer's man-offset inputs.

Parameters:
- TICK_W, 20, frame-tick divider width; one tick every 2^TICK_W clk_machine cycles (about 42 ms at 25 MHz).
- V0, 8, initial vertical velocity in pixels/frame; flight lasts 2*V0+1 frames.
- DX_W, 10, width of the horizontal offset.
- DY_W, 8, width of the vertical offset; must satisfy V0*(V0+1)/2 < 2^DY_W.

Ports:
- clk_machine  in  1  system clock, 25 MHz.
- rst_machine  in  1  asynchronous reset, active-low.
- state  in  3  top-level state code; uses IDLE/ACCU/JUMP codes from the shared package.
- squeeze_lvl  in  3  charge level from the squeeze counter, 0..7.
- o_dx  out  DX_W  horizontal offset from the take-off point, unsigned.
- o_dy  out  DY_W  height above the take-off line, unsigned.
- o_jumping  out  1  high while in FLIGHT.
- o_land  out  1  one-clk_machine pulse on touchdown.
- o_squeeze_man  out  3  landing recoil level; 0 when the optional feature is absent.

Behaviour:
- Reset (rst_machine=0, asynchronous): all outputs 0, FSM=IDLE, tick divider=0, prev_state=IDLE, charge=0, vy=0, frame=0.
- Tick divider: free-running TICK_W-bit counter. tick is asserted for one cycle when the counter is all-ones.
- prev_state: registered copy of state, updated every cycle.
- FSM states: IDLE, FLIGHT, RECOIL (RECOIL exists only with the optional feature).
- IDLE -> FLIGHT:
  - Trigger: prev_state==ACCU and state==JUMP, detected on the same clk edge it occurs.
  - Latch charge=squeeze_lvl, vy=V0, frame=0, o_dx=0, o_dy=0.
  - o_jumping=1 from the next cycle.
- FLIGHT, on each tick (in order, same edge):
  - o_dx += charge+1
  - o_dy += vy (vy treated as signed)
  - vy -= 1
  - frame += 1
- FLIGHT end:
  - When frame reaches 2*V0+1, o_dy is exactly 0 and o_dx = (2*V0+1)*(charge+1).
  - On that same edge: o_land=1 for one cycle, o_jumping=0, and the next state is RECOIL (feature on) or IDLE (feature off).
  - o_dx holds its final value until the next take-off.
- Arithmetic: vy is a signed register of width log2(V0)+2. o_dy never underflows given the frame bound. o_dx is wide enough for 17*8=136 at defaults, with no wrap.
- Abort: if state != JUMP while in FLIGHT, go to IDLE next cycle, clear o_dy and o_jumping, and suppress o_land. o_dx retains its value.
- Retrigger: an ACCU->JUMP edge is ignored unless the FSM is in IDLE.
- A tick coinciding with take-off is not applied; the first trajectory step is on the next tick.
- Lifecycle: squeeze_lvl is sampled only at take-off; later changes have no effect.

Optional Feature:
- Macro: MAN_JUMP_RECOIL_EN.
- Defined:
  - On landing, enter RECOIL with o_squeeze_man=3.
  - Decrement o_squeeze_man by 1 per tick; return to IDLE on the tick where it reaches 0.
  - Abort and ACCU->JUMP edges during RECOIL are ignored.
- Undefined: no RECOIL state; o_squeeze_man is tied to 0; landing goes directly to IDLE.

Decomposition:
- Shared package (jump_pkg): top-level state codes (IDLE, ACCU, JUMP, ...), the local FSM state enum, and the default V0 / TICK_W constants, shared with the squeeze counter and top FSM.
- One natural sub-module: frame_tick_gen, a parameterised TICK_W divider producing the single-cycle tick. It is reused by the squeeze counter refactor.

Test Plan (TICK_W=4, V0=8):
1. Reset mid-flight: deassert rst_machine during FLIGHT -> all outputs 0 immediately (asynchronous); after release, FSM is in IDLE and no o_land pulse occurs.
2. squeeze_lvl=7, drive ACCU then JUMP -> o_dy sequence per tick is 8,15,21,26,30,33,35,36,36,35,...,8,0. Final o_dx=136. o_land pulses once, on the tick where o_dy returns to 0.
3. squeeze_lvl=0 -> final o_dx=17 and the o_dy profile is identical to scenario 2; squeeze_lvl change after take-off has no effect.
4. Abort: state forced to IDLE after 5 ticks -> next cycle o_dy=0 and o_jumping=0; o_dx stays at 5*(charge+1); no o_land.
5. JUMP asserted without a preceding ACCU, or ACCU->JUMP during FLIGHT -> no take-off and no trajectory change.
6. With MAN_JUMP_RECOIL_EN: after landing, o_squeeze_man reads 3,2,1,0 on successive ticks, then the FSM returns to IDLE. Without the macro: o_squeeze_man is 0 throughout and a new take-off is accepted the cycle after o_land.
